// File: rtl/aes_sbox_arbiter.sv
// Purpose: time-shares one external 128-bit SubBytes array between the round datapath (port 0) and the key schedule (port 1).
// Latency: 2 cycles. The accept edge loads S1, and the next edge loads S2 and presents the result.
// Backpressure: a stalled response freezes S2 and S1, and requests are refused until S1 can move.
module aes_sbox_arbiter #(
  parameter int unsigned PRIO_MODE = 0  // 0: round-robin, 1: port 0 always wins ties
) (
  input  logic         clk,
  input  logic         rst_n,
  // port 0: cipher round datapath
  input  logic         req0_valid,
  input  logic [127:0] req0_data,
  output logic         req0_ready,
  output logic         rsp0_valid,
  output logic [127:0] rsp0_data,
  input  logic         rsp0_ready,
  // port 1: key expansion / auxiliary user
  input  logic         req1_valid,
  input  logic [127:0] req1_data,
  output logic         req1_ready,
  output logic         rsp1_valid,
  output logic [127:0] rsp1_data,
  input  logic         rsp1_ready,
  // shared combinational SubBytes
  output logic [127:0] sb_data,
  input  logic [127:0] sb_data_out,
  output logic         busy
);

  // One pipeline slot: occupancy, owning port and the 128-bit state it carries.
  typedef struct packed {
    logic         vld;
    logic         id;
    logic [127:0] dat;
  } stage_t;

  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;
  logic   last_grant_q, last_grant_d;

  logic   s2_free;
  logic   s1_adv;
  logic   can_accept;
  logic   grant;
  logic   acc_vld;

  // Pipeline flow control: S2 drains when its owner takes the result, and S1 moves when S2 is free.
  always_comb begin
    s2_free    = !s2_q.vld || (s2_q.id ? rsp1_ready : rsp0_ready);
    s1_adv     = s1_q.vld && s2_free;
    can_accept = !s1_q.vld || s1_adv;
  end

  // Arbitration: a lone requester wins, and a tie goes to port 0 or to the port opposite last_grant.
  always_comb begin
    grant = 1'b0;
    if (req1_valid && !req0_valid) begin
      grant = 1'b1;
    end else if (req1_valid && req0_valid) begin
      grant = (PRIO_MODE != 0) ? 1'b0 : !last_grant_q;
    end
  end

  // Ready is qualified by the port's own valid, so it never rises on an idle port.
  assign req0_ready = can_accept && !grant && req0_valid;
  assign req1_ready = can_accept &&  grant && req1_valid;
  assign acc_vld    = req0_ready || req1_ready;

  // Next state: accept into S1, move S1 through SubBytes into S2, retire consumed results.
  always_comb begin
    s1_d         = s1_q;
    s2_d         = s2_q;
    last_grant_d = last_grant_q;

    if (acc_vld) begin
      s1_d.vld     = 1'b1;
      s1_d.id      = grant;
      s1_d.dat     = grant ? req1_data : req0_data;
      last_grant_d = grant;
    end else if (s1_adv) begin
      s1_d.vld = 1'b0;
    end

    if (s1_adv) begin
      s2_d.vld = 1'b1;
      s2_d.id  = s1_q.id;
      s2_d.dat = sb_data_out;
    end else if (s2_q.vld && s2_free) begin
      s2_d.vld = 1'b0;
    end
  end

  // State registers. Reset discards anything in flight, so port 0 wins the first tie.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q         <= '0;
      s2_q         <= '0;
      last_grant_q <= 1'b1;
    end else begin
      s1_q         <= s1_d;
      s2_q         <= s2_d;
      last_grant_q <= last_grant_d;
    end
  end

  // S1 drives the shared S-box directly, and S2 is steered only to the port that owns it.
  assign sb_data    = s1_q.dat;
  assign rsp0_valid = s2_q.vld && !s2_q.id;
  assign rsp1_valid = s2_q.vld &&  s2_q.id;
  assign rsp0_data  = s2_q.id ? '0 : s2_q.dat;
  assign rsp1_data  = s2_q.id ? s2_q.dat : '0;
  assign busy       = s1_q.vld || s2_q.vld;

  // A response the consumer has not taken must stay put until it is taken.
  a_rsp0_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp0_valid && !rsp0_ready) |=> (rsp0_valid && $stable(rsp0_data)));
  a_rsp1_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp1_valid && !rsp1_ready) |=> (rsp1_valid && $stable(rsp1_data)));

endmodule

// File: tb/tb_aes_sbox_arbiter.sv
// Bench for aes_sbox_arbiter: one round-robin and one fixed-priority instance share the stimulus.
// Each instance is compared every cycle against a capacity-2 ordered-buffer model with an arithmetic S-box.
// Directed scenarios pin literal results, and randomized traffic follows them.
module tb_aes_sbox_arbiter;

  logic         clk;
  logic         rst_n;
  logic [1:0]   rq_v;
  logic [127:0] r0d, r1d;
  logic [1:0]   rs_r;

  logic [1:0]          rdy0, rdy1, vld0, vld1, busy;
  logic [1:0][127:0]   dat0, dat1, sbd, sbo;

  int total = 0;
  int bad   = 0;

  // ---------------- GF(2^8) S-box, computed arithmetically ----------------
  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] r, x;
    r = 8'h00;
    x = a;
    for (int k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ x;
      x = xt(x);
    end
    return r;
  endfunction

  function automatic logic [7:0] sbox_byte(input logic [7:0] a);
    logic [7:0] p, inv, r, x;
    // a^254 is the multiplicative inverse (and 0 maps to 0)
    p   = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      p   = gmul(p, p);
      inv = gmul(inv, p);
    end
    r = inv;
    x = inv;
    for (int k = 0; k < 4; k++) begin
      x = {x[6:0], x[7]};
      r = r ^ x;
    end
    return r ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_word(input logic [127:0] d);
    logic [127:0] w;
    w = '0;
    for (int k = 0; k < 16; k++) w[8*k +: 8] = sbox_byte(d[8*k +: 8]);
    return w;
  endfunction

  // ---------------- DUTs ----------------
  aes_sbox_arbiter #(.PRIO_MODE(0)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rq_v[0]), .req0_data(r0d), .req0_ready(rdy0[0]),
    .rsp0_valid(vld0[0]), .rsp0_data(dat0[0]), .rsp0_ready(rs_r[0]),
    .req1_valid(rq_v[1]), .req1_data(r1d), .req1_ready(rdy1[0]),
    .rsp1_valid(vld1[0]), .rsp1_data(dat1[0]), .rsp1_ready(rs_r[1]),
    .sb_data(sbd[0]), .sb_data_out(sbo[0]), .busy(busy[0])
  );

  aes_sbox_arbiter #(.PRIO_MODE(1)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(rq_v[0]), .req0_data(r0d), .req0_ready(rdy0[1]),
    .rsp0_valid(vld0[1]), .rsp0_data(dat0[1]), .rsp0_ready(rs_r[0]),
    .req1_valid(rq_v[1]), .req1_data(r1d), .req1_ready(rdy1[1]),
    .rsp1_valid(vld1[1]), .rsp1_data(dat1[1]), .rsp1_ready(rs_r[1]),
    .sb_data(sbd[1]), .sb_data_out(sbo[1]), .busy(busy[1])
  );

  assign sbo[0] = sub_word(sbd[0]);
  assign sbo[1] = sub_word(sbd[1]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // ---------------- behavioural model: ordered buffer of up to 2 requests ----------------
  // The head is visible as a response unless it was pushed at the most recent edge.
  logic         mq_id  [2][2];
  logic [127:0] mq_dat [2][2];
  int           msz [2];
  bit           mfr [2];   // tail entry was accepted on the most recent edge
  bit           mlg [2];   // last granted port
  bit           mv = 1'b0;

  task automatic model_cycle(input int i, input bit step);
    bit hv, pop, can, g, e0, e1;
    hv  = (msz[i] > 0) && !(msz[i] == 1 && mfr[i]);
    pop = hv && rs_r[mq_id[i][0]];
    can = (msz[i] - int'(pop)) < 2;
    g   = rq_v[1] && (!rq_v[0] || (i == 0 && !mlg[i]));
    e0  = can && !g && rq_v[0];
    e1  = can &&  g && rq_v[1];
    check($sformatf("m%0d req0_ready", i), rdy0[i], e0);
    check($sformatf("m%0d req1_ready", i), rdy1[i], e1);
    check($sformatf("m%0d rsp0_valid", i), vld0[i], hv && mq_id[i][0] == 1'b0);
    check($sformatf("m%0d rsp1_valid", i), vld1[i], hv && mq_id[i][0] == 1'b1);
    check($sformatf("m%0d busy", i), busy[i], msz[i] > 0);
    if (hv && mq_id[i][0] == 1'b0) check($sformatf("m%0d rsp0_data", i), dat0[i], sub_word(mq_dat[i][0]));
    if (hv && mq_id[i][0] == 1'b1) check($sformatf("m%0d rsp1_data", i), dat1[i], sub_word(mq_dat[i][0]));
    if (msz[i] == 2) check($sformatf("m%0d sb_data", i), sbd[i], mq_dat[i][1]);
    else if (msz[i] == 1 && mfr[i]) check($sformatf("m%0d sb_data", i), sbd[i], mq_dat[i][0]);
    if (step) begin
      if (pop) begin
        mq_id[i][0]  = mq_id[i][1];
        mq_dat[i][0] = mq_dat[i][1];
        msz[i]--;
      end
      if (e0 || e1) begin
        mq_id[i][msz[i]]  = g;
        mq_dat[i][msz[i]] = g ? r1d : r0d;
        msz[i]++;
        mfr[i] = 1'b1;
        mlg[i] = g;
      end else begin
        mfr[i] = 1'b0;
      end
    end
  endtask

  // Compare every cycle, then advance the model across the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      if (mv) for (int i = 0; i < 2; i++) model_cycle(i, 1'b0);
      for (int i = 0; i < 2; i++) begin
        msz[i] = 0;
        mfr[i] = 1'b0;
        mlg[i] = 1'b1;
        mq_id[i][0] = 1'b0; mq_id[i][1] = 1'b0;
        mq_dat[i][0] = '0;  mq_dat[i][1] = '0;
      end
      mv = 1'b1;
    end else if (mv) begin
      for (int i = 0; i < 2; i++) model_cycle(i, 1'b1);
    end
  end

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  localparam logic [127:0] V1 = 128'h001F0E54_3C4E0859_6E221B0B_4774311A;
  localparam logic [127:0] E1 = 128'h63C0AB20_EB2F30CB_9F93AF2B_A092C7A2;
  localparam logic [127:0] VA = 128'hAABBCCDD_EEFF1234_569867B3_45EF9348;
  localparam logic [127:0] EA = 128'hACEA4BC1_2816C918_B146856D_6EDFDC52;
  localparam logic [127:0] VB = 128'h1376B123_DF690103_B00A9876_FACD628B;
  localparam logic [127:0] EB = 128'h7D38C826_9EF97C7B_E7674638_2DBDAA3D;
  localparam logic [127:0] VP = 128'h02B674C5_AF79ADCB_FEBA3F9A_0F9B7ABC;
  localparam logic [127:0] EP = 128'h774E92A6_79B6951F_BBF475B8_7614DA65;
  localparam logic [127:0] VQ = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] E63 = {16{8'h63}};

  initial begin
    rst_n = 1'b0; rq_v = 2'b00; r0d = '0; r1d = '0; rs_r = 2'b11;
    repeat (3) nxt;
    rst_n = 1'b1;

    // reset state and S-box model pins
    @(negedge clk);
    check("pin sbox(00)", sbox_byte(8'h00), 8'h63);
    check("pin sbox(01)", sbox_byte(8'h01), 8'h7c);
    check("pin sbox(53)", sbox_byte(8'h53), 8'hed);
    check("pin sub_word(V1)", sub_word(V1), E1);
    for (int i = 0; i < 2; i++) begin
      check("reset rdy", {rdy1[i], rdy0[i]}, 2'b00);
      check("reset rsp_valid", {vld1[i], vld0[i]}, 2'b00);
      check("reset rsp0_data", dat0[i], '0);
      check("reset rsp1_data", dat1[i], '0);
      check("reset sb_data", sbd[i], '0);
      check("reset busy", busy[i], 1'b0);
    end

    // single port-0 request
    nxt; rq_v = 2'b01; r0d = V1;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("single accept", rdy0[i], 1'b1);
    nxt; rq_v = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("single in S1", {busy[i], vld0[i]}, 2'b10);
    nxt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("single rsp0_valid", vld0[i], 1'b1);
      check("single rsp0_data", dat0[i], E1);
      check("single rsp1_valid", vld1[i], 1'b0);
    end
    nxt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("single idle", {busy[i], vld0[i], vld1[i]}, 3'b000);

    // both ports continuously valid
    rst_n = 1'b0; nxt; nxt; rst_n = 1'b1;
    rq_v = 2'b11; r0d = VA; r1d = VB;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check($sformatf("rr grant k=%0d", k), {rdy1[0], rdy0[0]}, (k % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("fp grant k=%0d", k), {rdy1[1], rdy0[1]}, 2'b01);
      if (k >= 2) begin
        check($sformatf("rr rsp k=%0d", k), {vld1[0], vld0[0]}, (k % 2 == 0) ? 2'b01 : 2'b10);
        if (k % 2 == 0) check("rr rsp0_data", dat0[0], EA);
        else            check("rr rsp1_data", dat1[0], EB);
        check($sformatf("fp rsp k=%0d", k), {vld1[1], vld0[1]}, 2'b01);
        check("fp rsp0_data", dat0[1], EA);
      end
      nxt;
    end
    rq_v = 2'b10;
    @(negedge clk);
    check("fp port1 on req0 drop", rdy1[1], 1'b1);
    nxt; rq_v = 2'b00;
    repeat (4) nxt;

    // port-1 backpressure
    rq_v = 2'b10; r1d = VP; rs_r = 2'b01;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("bp accept first", rdy1[i], 1'b1);
    nxt; r1d = VQ;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("bp accept second", rdy1[i], 1'b1);
    nxt; rq_v = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        check("bp rsp1_valid", vld1[i], 1'b1);
        check("bp rsp1_data", dat1[i], EP);
        check("bp all ready low", {rdy1[i], rdy0[i]}, 2'b00);
      end
      nxt;
    end
    rs_r = 2'b11; rq_v = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("drain first", dat1[i], EP);
    nxt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("drain second valid", vld1[i], 1'b1);
      check("drain second data", dat1[i], sub_word(VQ));
    end
    nxt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("drain idle", busy[i], 1'b0);

    // reset with two requests in flight
    rs_r = 2'b00;
    rq_v = 2'b01; r0d = {$urandom, $urandom, $urandom, $urandom};
    nxt; rq_v = 2'b10; r1d = {$urandom, $urandom, $urandom, $urandom};
    nxt; rq_v = 2'b00;
    rst_n = 1'b0; nxt; nxt; rst_n = 1'b1; rs_r = 2'b11;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) check("post-reset quiet", {busy[i], vld1[i], vld0[i]}, 3'b000);
      nxt;
    end
    rq_v = 2'b01; r0d = '0;
    nxt; rq_v = 2'b00;
    nxt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("zero rsp0_valid", vld0[i], 1'b1);
      check("zero rsp0_data", dat0[i], E63);
    end
    nxt;

    // randomized traffic with random backpressure and occasional reset
    for (int n = 0; n < 3000; n++) begin
      rq_v  = 2'($urandom_range(0, 3));
      r0d   = {$urandom, $urandom, $urandom, $urandom};
      r1d   = {$urandom, $urandom, $urandom, $urandom};
      rs_r  = {($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0)};
      rst_n = ($urandom_range(0, 399) != 0);
      nxt;
    end
    rq_v = 2'b00; rs_r = 2'b11; rst_n = 1'b1;
    repeat (4) nxt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) check("final idle", busy[i], 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
